sr_ff_bank: RTL and testbench
=============================

// Module: sr_ff_bank
// PURPOSE
//   Parametrised bank of WIDTH clocked SR flip-flops. It replaces the single
//   asynchronous NAND SR latch in synchronous datapaths.
//   - Deterministic S=R=1 resolution selected by MODE.
//   - Guaranteed complementary outputs.
//   - Per-channel change strobes and an invalid-input flag for status and
//     interrupt logic.
// PARAMETERS
//   WIDTH  8  number of independent SR channels (>=1)
//   MODE   0  S=R=1 policy: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle;
//             values >3 behave as 0
//   CNT_W  8  width of invalid-event counter (only used with SR_INV_CNT_EN)
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   en         in   1      update enable; when 0 all state holds
//   s          in   WIDTH  per-channel set request
//   r          in   WIDTH  per-channel reset request
//   q          out  WIDTH  registered state
//   q_bar      out  WIDTH  registered complement of q
//   q_chg      out  WIDTH  1-cycle strobe, channel q changed on last edge
//   invalid    out  1      1-cycle strobe, some channel had s=r=1 with en=1
//   inv_count  out  CNT_W  saturating invalid-cycle count (SR_INV_CNT_EN only)
// BEHAVIOUR
//   - All outputs are registered and update only on the rising edge of clk.
//     There is no combinational input->output path.
//   - Reset: rst=1 at an edge forces q=0, q_bar=all ones, q_chg=0, invalid=0,
//     inv_count=0. rst overrides en and s/r. Reset asserted mid-sequence
//     discards any pending state. The first post-reset edge with en=1 acts
//     normally.
//   - en=0 at an edge: q and q_bar hold; q_chg=0; invalid=0; counter holds.
//   - Per channel i, at an edge with en=1 and rst=0:
//       s=0 r=0 -> q holds
//       s=0 r=1 -> q=0
//       s=1 r=0 -> q=1
//       s=1 r=1 -> MODE 0 hold, MODE 1 q=1, MODE 2 q=0, MODE 3 q=~q
//   - Latency: 1 cycle from s/r sample to q, q_bar, q_chg and invalid.
//   - q_bar == ~q on every cycle, including reset and S=R=1. The forbidden
//     q=q_bar state of the NAND latch is unreachable.
//   - q_chg[i] = (new q[i] != old q[i]). It is registered alongside q and
//     cleared the next edge unless q changes again.
//   - invalid = OR over channels of (s[i]&r[i]), qualified by en, registered.
//     It asserts under every MODE; S=R=1 is legal but flagged.
//   - Channels are fully independent. Simultaneous S=R=1 on several channels
//     produces one invalid pulse.
// CONFIGURATION
//   SR_INV_CNT_EN defined:
//     - inv_count port present.
//     - Increments by 1 on each edge where invalid is set, regardless of how
//       many channels were invalid that cycle.
//     - Saturates at 2^CNT_W-1 with no wrap.
//     - Cleared only by rst.
//   SR_INV_CNT_EN undefined:
//     - inv_count port and counter logic absent.
//     - All other behaviour identical.
// TESTING
//   1. rst=1 for 2 edges, s=r=all ones -> q=0x00, q_bar=0xFF, q_chg=0,
//      invalid=0.
//   2. WIDTH=8, MODE=0:
//      - en=1, s=0x0F, r=0 -> next cycle q=0x0F, q_chg=0x0F.
//      - then s=r=0 -> q=0x0F, q_chg=0.
//      - then r=0x03 -> q=0x0C, q_chg=0x03.
//   3. MODE sweep with q=0x0F, s=r=0xFF, en=1, one edge:
//      - MODE0 -> q=0x0F
//      - MODE1 -> q=0xFF
//      - MODE2 -> q=0x00
//      - MODE3 -> q=0xF0
//      - invalid=1 in all cases.
//   4. Gating: en=0 with s=0xFF for 3 edges -> q unchanged, invalid=0,
//      q_chg=0.
//   5. Reset during toggle: MODE=3, s=r=0x01 toggling q[0] each edge; assert
//      rst mid-run -> q=0 next edge; release -> toggling resumes from 0.
//   6. SR_INV_CNT_EN, CNT_W=2: 5 consecutive invalid cycles -> inv_count
//      reads 1,2,3,3,3; invalid cycles with en=0 are not counted.

Source files
------------

// File: rtl/sr_ff_bank_if.sv
// Bus bundle for sr_ff_bank: per-channel set/reset requests in, registered state and status out.
// The inv_count signal exists only when SR_INV_CNT_EN is defined.
interface sr_ff_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             en;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic [WIDTH-1:0] q_chg;
  logic             invalid;
`ifdef SR_INV_CNT_EN
  logic [CNT_W-1:0] inv_count;
`endif

  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
    $error("sr_ff_bank_if: WIDTH and CNT_W must be >= 1");
  end

  modport master (
    output en, s, r,
    input  q, q_bar, q_chg, invalid
`ifdef SR_INV_CNT_EN
    , input inv_count
`endif
  );

  modport slave (
    input  en, s, r,
    output q, q_bar, q_chg, invalid
`ifdef SR_INV_CNT_EN
    , output inv_count
`endif
  );
endinterface

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH clocked SR flip-flops with selectable S=R=1 policy, change strobes and invalid flag.
// Optional saturating invalid-event counter enabled by defining SR_INV_CNT_EN.
module sr_ff_bank #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input logic        clk,
  input logic        rst,
  sr_ff_bank_if.slave bus
);
  typedef enum logic [1:0] {
    SRR_HOLD   = 2'd0,
    SRR_SET    = 2'd1,
    SRR_RESET  = 2'd2,
    SRR_TOGGLE = 2'd3
  } srr_t;

  // Out-of-range MODE values fall back to hold.
  function automatic srr_t policy_f(input int m);
    case (m)
      1:       return SRR_SET;
      2:       return SRR_RESET;
      3:       return SRR_TOGGLE;
      default: return SRR_HOLD;
    endcase
  endfunction

  localparam srr_t POLICY = policy_f(MODE);

  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
    $error("sr_ff_bank: WIDTH and CNT_W must be >= 1");
  end

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_bar_r;
  logic [WIDTH-1:0] q_chg_r;
  logic             invalid_r;
  logic [WIDTH-1:0] nxt;
  logic             any_inv;

  assign any_inv = |(bus.s & bus.r);

  always_comb begin
    nxt = q_r;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      unique case ({bus.s[i], bus.r[i]})
        2'b10: nxt[i] = 1'b1;
        2'b01: nxt[i] = 1'b0;
        2'b11: begin
          case (POLICY)
            SRR_SET:    nxt[i] = 1'b1;
            SRR_RESET:  nxt[i] = 1'b0;
            SRR_TOGGLE: nxt[i] = ~q_r[i];
            default:    nxt[i] = q_r[i];
          endcase
        end
        default: nxt[i] = q_r[i];
      endcase
    end
  end

  // q_bar is its own register loaded with ~nxt, so it is complementary on every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r       <= '0;
      q_bar_r   <= '1;
      q_chg_r   <= '0;
      invalid_r <= 1'b0;
    end else if (bus.en) begin
      q_r       <= nxt;
      q_bar_r   <= ~nxt;
      q_chg_r   <= nxt ^ q_r;
      invalid_r <= any_inv;
    end else begin
      q_chg_r   <= '0;
      invalid_r <= 1'b0;
    end
  end

  assign bus.q       = q_r;
  assign bus.q_bar   = q_bar_r;
  assign bus.q_chg   = q_chg_r;
  assign bus.invalid = invalid_r;

`ifdef SR_INV_CNT_EN
  logic [CNT_W-1:0] cnt_r;

  // Counts on the same edge that sets invalid, saturating at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (bus.en && any_inv && (cnt_r != '1)) begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign bus.inv_count = cnt_r;
`endif
endmodule

// File: tb/tb_sr_ff_bank.sv
// Scoreboard bench for sr_ff_bank: five instances (MODE 0,1,2,3,5) share one stimulus stream.
// Counter checks are active when SR_INV_CNT_EN is defined (CNT_W=2).
module tb_sr_ff_bank;
  localparam int NDUT = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] s   = '0;
  logic [7:0] r   = '0;

  logic [NDUT-1:0][7:0] q_o;
  logic [NDUT-1:0][7:0] qb_o;
  logic [NDUT-1:0][7:0] chg_o;
  logic [NDUT-1:0]      inv_o;
  logic [NDUT-1:0][1:0] cnt_o;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int M = (g == 4) ? 5 : g;
    sr_ff_bank_if #(.WIDTH(8), .CNT_W(2)) ifc ();
    assign ifc.en    = en;
    assign ifc.s     = s;
    assign ifc.r     = r;
    assign q_o[g]    = ifc.q;
    assign qb_o[g]   = ifc.q_bar;
    assign chg_o[g]  = ifc.q_chg;
    assign inv_o[g]  = ifc.invalid;
`ifdef SR_INV_CNT_EN
    assign cnt_o[g]  = ifc.inv_count;
`else
    assign cnt_o[g]  = '0;
`endif
    sr_ff_bank #(.WIDTH(8), .MODE(M), .CNT_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
    );
  end

  typedef struct packed {
    logic [3:0][7:0] q;
    logic            inv;
    logic [1:0]      cnt;
    logic            rst;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: each edge after stimulus was queued, pop the expectation and compare.
  logic [3:0][7:0] prev = '0;
  always begin
    exp_t e;
    int   mi;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int m = 0; m < NDUT; m++) begin
        mi = (m == 4) ? 0 : m;
        chk($sformatf("q[dut%0d]", m), q_o[m], e.q[mi]);
        chk($sformatf("q_bar[dut%0d]", m), qb_o[m], ~e.q[mi]);
        chk($sformatf("q_chg[dut%0d]", m), chg_o[m], e.rst ? 8'h00 : (e.q[mi] ^ prev[mi]));
        chk($sformatf("invalid[dut%0d]", m), {7'b0, inv_o[m]}, {7'b0, e.inv});
`ifdef SR_INV_CNT_EN
        chk($sformatf("inv_count[dut%0d]", m), {6'b0, cnt_o[m]}, {6'b0, e.cnt});
`endif
      end
      prev = e.q;
    end
  end

  task automatic step(input logic rs, input logic e_n, input logic [7:0] sv, input logic [7:0] rv,
                      input logic [7:0] q0, input logic [7:0] q1, input logic [7:0] q2,
                      input logic [7:0] q3, input logic iv, input logic [1:0] c);
    exp_t x;
    @(posedge clk);
    #2;
    rst = rs; en = e_n; s = sv; r = rv;
    x.q   = {q3, q2, q1, q0};
    x.inv = iv;
    x.cnt = c;
    x.rst = rs;
    sb.push_back(x);
  endtask

  initial begin
    // reset with every request asserted
    step(1, 1, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    step(1, 1, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    // basic set / hold / reset
    step(0, 1, 8'h0F, 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 0, 0);
    step(0, 1, 8'h00, 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 0, 0);
    step(0, 1, 8'h00, 8'h03, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 0, 0);
    step(0, 1, 8'h03, 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 0, 0);
    // S=R=1 sweep from q=0x0F
    step(0, 1, 8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'h00, 8'hF0, 1, 1);
    // gated: invalid with en=0 is not flagged or counted
    step(0, 0, 8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'h00, 8'hF0, 0, 1);
    for (int k = 0; k < 3; k++)
      step(0, 0, 8'hFF, 8'h00, 8'h0F, 8'hFF, 8'h00, 8'hF0, 0, 1);
    // further invalid cycles: counter saturates at 3
    step(0, 1, 8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'h00, 8'h0F, 1, 2);
    step(0, 1, 8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'h00, 8'hF0, 1, 3);
    step(0, 1, 8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'h00, 8'h0F, 1, 3);
    step(0, 1, 8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'h00, 8'hF0, 1, 3);
    // independent channels: set bit 7, reset bit 0
    step(0, 1, 8'h80, 8'h01, 8'h8E, 8'hFE, 8'h80, 8'hF0, 0, 3);
    // toggle on channel 0, reset mid-run, resume from 0
    step(0, 1, 8'h01, 8'h01, 8'h8E, 8'hFF, 8'h80, 8'hF1, 1, 3);
    step(0, 1, 8'h01, 8'h01, 8'h8E, 8'hFF, 8'h80, 8'hF0, 1, 3);
    step(1, 1, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    step(0, 1, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 1, 1);
    step(0, 1, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 1, 2);
    step(0, 1, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 1, 3);
    step(0, 0, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 0, 3);

    repeat (4) @(posedge clk);
    #3;
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
